// File: rtl/orb_pkg.sv
// orb_pkg: shared FSM type, defaults and helpers for the raster pixel feeder
package orb_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} feeder_state_t;
  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam int WIN_DEF = 37;
  localparam int COORD_W = 10;
  localparam int PAD_ROWS = WIN_DEF / 2;
  function automatic int pad_rows(input int win);
    return win / 2;
  endfunction
endpackage

// File: rtl/raster_pixel_feeder_xy_counter.sv
// xy_counter: raster coordinate counter holding the coordinate of the next pixel
// Ports: clk, rst (sync, active-low), advance (step one pixel), clear (restart at 0,0;
// with advance the restart pixel itself is consumed), x/y, last_in_row, last_in_frame.
module xy_counter
  import orb_pkg::*;
#(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic               clear,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last_in_row,
  output logic               last_in_frame
);
  logic [COORD_W-1:0] x_q, y_q;
  assign x = x_q;
  assign y = y_q;
  assign last_in_row = x_q == COORD_W'(IMG_WIDTH - 1);
  assign last_in_frame = last_in_row && y_q == COORD_W'(IMG_HEIGHT - 1);
  // y is not wrapped: padding rows continue counting past the image bottom
  always_ff @(posedge clk)
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clear) begin
      x_q <= advance ? COORD_W'(1) : '0;
      y_q <= '0;
    end else if (advance) begin
      x_q <= last_in_row ? '0 : x_q + COORD_W'(1);
      y_q <= last_in_row ? y_q + COORD_W'(1) : y_q;
    end
endmodule

// File: rtl/raster_pixel_feeder.sv
// raster_pixel_feeder: feeds a raster pixel stream into the 37-row line buffer and tracks column coordinates
// Ports: s_valid/s_ready/s_pixel/s_sof upstream stream; hold downstream stall;
// ena/pixel line-buffer drive; col_x/col_y/col_valid column tag aligned with e1..e37;
// frame_done end-of-frame pulse; err_sof sticky mid-frame start-of-frame flag.
// Reset rst is synchronous, active-low. Define BORDER_PAD_EN to append WIN/2 padding rows.
module raster_pixel_feeder
  import orb_pkg::*;
#(
  parameter int                     PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int                     IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int                     IMG_HEIGHT  = IMG_HEIGHT_DEF,
  parameter int                     WIN         = WIN_DEF,
  parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [PIXEL_WIDTH-1:0] s_pixel,
  input  logic                   s_sof,
  input  logic                   hold,
  output logic                   ena,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic [COORD_W-1:0]     col_x,
  output logic [COORD_W-1:0]     col_y,
  output logic                   col_valid,
  output logic                   frame_done,
  output logic                   err_sof
);
`ifdef BORDER_PAD_EN
  localparam feeder_state_t END_STATE = FLUSH;
`else
  localparam feeder_state_t END_STATE = DONE;
`endif
  localparam logic [COORD_W-1:0] LAST_PAD_Y = COORD_W'(IMG_HEIGHT + pad_rows(WIN) - 1);
  feeder_state_t state_q, state_d;
  logic [COORD_W-1:0] x, y, cx, cy, col_x_q, col_y_q;
  logic last_in_row, last_in_frame, run, acc, sof_acc, in_col;
  logic col_valid_q, frame_done_q, err_sof_q;
  assign run = rst && !hold;
  assign s_ready = run && (state_q == IDLE || state_q == STREAM);
  assign acc = s_valid && s_ready;
  assign sof_acc = acc && s_sof;
  // IDLE only lets the start-of-frame beat through; FLUSH shifts every unstalled cycle
  assign ena = state_q == FLUSH ? run : acc && (state_q == STREAM || s_sof);
  assign pixel = !rst ? '0 : state_q == FLUSH ? PAD_VALUE : s_pixel;
  // a start-of-frame beat is always pixel (0,0), whatever the counter held
  assign cx = sof_acc ? '0 : x;
  assign cy = sof_acc ? '0 : y;
`ifdef BORDER_PAD_EN
  assign in_col = cy >= COORD_W'(WIN - 1);
`else
  assign in_col = cy >= COORD_W'(WIN - 1) && cy < COORD_W'(IMG_HEIGHT);
`endif
  xy_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT)) u_xy (
    .clk(clk),
    .rst(rst),
    .advance(ena),
    .clear(sof_acc || state_q == DONE),
    .x(x),
    .y(y),
    .last_in_row(last_in_row),
    .last_in_frame(last_in_frame)
  );
  always_comb begin
    state_d = state_q;
    if (sof_acc) state_d = STREAM;
    else if (state_q == STREAM && acc && last_in_frame) state_d = END_STATE;
    else if (state_q == FLUSH && run && last_in_row && y == LAST_PAD_Y) state_d = DONE;
    else if (state_q == DONE && run) state_d = IDLE;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      col_x_q <= '0;
      col_y_q <= '0;
      col_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      err_sof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_done_q <= state_d == DONE && state_q != DONE;
      err_sof_q <= err_sof_q || (sof_acc && state_q == STREAM);
      col_valid_q <= ena && in_col;
      col_x_q <= ena ? cx : col_x_q;
      col_y_q <= ena ? cy : col_y_q;
    end
  assign col_x = col_x_q;
  assign col_y = col_y_q;
  assign col_valid = col_valid_q;
  assign frame_done = frame_done_q;
  assign err_sof = err_sof_q;
endmodule

// File: tb/tb_raster_pixel_feeder.sv
// tb_raster_pixel_feeder: directed self-checking bench for raster_pixel_feeder (8x40 image, WIN=37)
module tb_raster_pixel_feeder;
`ifdef BORDER_PAD_EN
  localparam bit PAD = 1'b1;
  localparam int CV_EXP = 176;
`else
  localparam bit PAD = 1'b0;
  localparam int CV_EXP = 32;
`endif
  logic clk = 1'b0, rst, s_valid, s_ready, s_sof, hold, ena, col_valid, frame_done, err_sof;
  logic [7:0] s_pixel, pixel;
  logic [9:0] col_x, col_y;
  int n_cmp = 0, n_bad = 0;
  raster_pixel_feeder #(
    .PIXEL_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(40), .WIN(37), .PAD_VALUE(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
    .s_sof(s_sof), .hold(hold), .ena(ena), .pixel(pixel), .col_x(col_x), .col_y(col_y),
    .col_valid(col_valid), .frame_done(frame_done), .err_sof(err_sof)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int bad, cv, first, fl_bad;
    rst = 1'b0; s_valid = 1'b1; s_sof = 1'b0; hold = 1'b0; s_pixel = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("rst_ready", s_ready, 0);
      chk("rst_ena", ena, 0);
      chk("rst_pixel", pixel, 0);
      chk("rst_colx", col_x, 0);
      chk("rst_coly", col_y, 0);
      chk("rst_colvalid", col_valid, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_errsof", err_sof, 0);
    end
    rst = 1'b1; s_valid = 1'b0;
    #1;
    chk("idle_ready", s_ready, 1);
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_pixel = 8'(i + 1);
      #1;
      chk("nosof_ready", s_ready, 1);
      chk("nosof_ena", ena, 0);
      tick;
    end
    s_sof = 1'b1; s_pixel = 8'h11;
    #1;
    chk("sof_ena", ena, 1);
    chk("sof_pixel", pixel, 8'h11);
    tick;
    s_sof = 1'b0;
    chk("sof_colx", col_x, 0);
    chk("sof_coly", col_y, 0);
    chk("sof_colvalid", col_valid, 0);
    bad = 0; cv = 0; first = -1;
    for (int i = 1; i < 320; i++) begin
      if (i == 5) begin
        hold = 1'b1; s_valid = 1'b1; s_pixel = 8'd5;
        for (int k = 0; k < 4; k++) begin
          #1;
          chk("hold_ready", s_ready, 0);
          chk("hold_ena", ena, 0);
          tick;
          chk("hold_colx", col_x, 4);
          chk("hold_colvalid", col_valid, 0);
        end
        hold = 1'b0;
      end
      s_valid = 1'b1; s_pixel = 8'(i);
      tick;
      if (i == 5) chk("resume_colx", col_x, 5);
      if (col_x !== 10'(i % 8) || col_y !== 10'(i / 8) || col_valid !== (i >= 288) ||
          frame_done !== (i == 319 && !PAD)) bad++;
      if (col_valid === 1'b1) begin
        cv++;
        if (first < 0) first = i;
      end
    end
    s_valid = 1'b0;
    chk("frame_coord_track", bad, 0);
    chk("colvalid_first_beat", first, 288);
`ifdef BORDER_PAD_EN
    fl_bad = 0;
    for (int k = 0; k < 144; k++) begin
      if (s_ready !== 1'b0 || ena !== 1'b1 || pixel !== 8'h00 || frame_done !== 1'b0) fl_bad++;
      tick;
      if (col_valid === 1'b1) cv++;
    end
    chk("flush_cycles", fl_bad, 0);
`else
    fl_bad = 0;
    chk("done_ready", s_ready, fl_bad);
`endif
    chk("colvalid_count", cv, CV_EXP);
    chk("frame_done_pulse", frame_done, 1);
    tick;
    chk("frame_done_clear", frame_done, 0);
    chk("back_idle_ready", s_ready, 1);
    chk("errsof_clean", err_sof, 0);
    s_valid = 1'b1; s_sof = 1'b1; s_pixel = 8'h22;
    #1;
    chk("f2_sof_ena", ena, 1);
    tick;
    s_sof = 1'b0;
    chk("f2_colx", col_x, 0);
    for (int i = 1; i < 83; i++) begin
      s_pixel = 8'(i);
      tick;
    end
    chk("f2_pre_colx", col_x, 2);
    chk("f2_pre_coly", col_y, 10);
    s_sof = 1'b1; s_pixel = 8'h33;
    tick;
    s_sof = 1'b0;
    chk("midsof_err", err_sof, 1);
    chk("midsof_colx", col_x, 0);
    chk("midsof_coly", col_y, 0);
    s_pixel = 8'h34;
    tick;
    chk("restart_colx", col_x, 1);
    chk("restart_coly", col_y, 0);
    s_valid = 1'b0;
    tick;
    tick;
    chk("err_sticky", err_sof, 1);
    chk("idle_hold_colx", col_x, 1);
    rst = 1'b0;
    tick;
    chk("err_cleared", err_sof, 0);
    chk("rst2_colx", col_x, 0);
    chk("rst2_ready", s_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst2_release_ready", s_ready, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
